// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads the combinational program memory and presents
// instructions with valid/ready. Define FETCH_BOUNDS_CHECK_EN to also fault on out-of-segment PCs.
module instruction_fetch_unit #(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = 32'h0040_0000,
    parameter int unsigned           MEMORY_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_instruction,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic                  fault
);

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    // One bit wider so the segment end cannot overflow near the top of the address space.
    localparam logic [DATA_WIDTH:0] SEG_LO = {1'b0, TEXT_BASE};
    localparam logic [DATA_WIDTH:0] SEG_HI = SEG_LO + (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        VALID = 2'b01,
        FAULT = 2'b10
    } state_t;

    state_t                  state_reg, state_next;
    logic [DATA_WIDTH-1:0]   pc_reg, pc_next;
    logic [DATA_WIDTH-1:0]   instr_reg, instr_next;
    logic [DATA_WIDTH-1:0]   instr_pc_reg, instr_pc_next;
    logic                    load_en;
    logic [DATA_WIDTH-1:0]   load_addr;

    function automatic logic pc_bad(input logic [DATA_WIDTH-1:0] a);
        logic [DATA_WIDTH:0] ax;
        ax = {1'b0, a};
        return (a[1:0] != 2'b00) || (BOUNDS_EN && ((ax < SEG_LO) || (ax >= SEG_HI)));
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= FETCH;
            pc_reg       <= TEXT_BASE;
            instr_reg    <= '0;
            instr_pc_reg <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            instr_reg    <= instr_next;
            instr_pc_reg <= instr_pc_next;
        end
    end

    // Redirect wins over sequential advance; every PC load passes the fault check.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        instr_next    = instr_reg;
        instr_pc_next = instr_pc_reg;
        load_en       = 1'b0;
        load_addr     = pc_reg + DATA_WIDTH'(4);
        case (state_reg)
            FETCH: begin
                if (redirect_valid) begin
                    load_en   = 1'b1;
                    load_addr = redirect_pc;
                end else begin
                    instr_next    = mem_instruction;
                    instr_pc_next = pc_reg;
                    state_next    = VALID;
                end
            end
            VALID: begin
                if (redirect_valid) begin
                    load_en   = 1'b1;
                    load_addr = redirect_pc;
                end else if (instr_ready) begin
                    load_en = 1'b1;
                end
            end
            default: ;
        endcase
        if (load_en) begin
            pc_next    = load_addr;
            state_next = pc_bad(load_addr) ? FAULT : FETCH;
        end
    end

    always_comb begin
        instr_valid = (state_reg == VALID);
        fault       = (state_reg == FAULT);
        mem_addr    = pc_reg;
        instr       = instr_reg;
        instr_pc    = instr_pc_reg;
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit: directed test-plan sequences followed by
// random redirect/ready traffic, all checked against a cycle-level behavioural model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] TB_BASE = 32'h0040_0000;
    localparam int          DEPTH   = 32;
`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BCHK = 1'b1;
`else
    localparam bit BCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_instruction;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fault;

    logic [31:0] mem [DEPTH];
    assign mem_instruction = mem[mem_addr[6:2]];

    instruction_fetch_unit #(
        .DATA_WIDTH  (32),
        .TEXT_BASE   (TB_BASE),
        .MEMORY_DEPTH(DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .mem_addr       (mem_addr),
        .mem_instruction(mem_instruction),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: "is an instruction held", "has the unit died", PC and held instruction.
    logic [31:0] m_pc, m_instr, m_ipc;
    bit          m_valid, m_fault;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        if (a[1:0] != 2'b00) return 1'b1;
        if (BCHK && ((a < TB_BASE) || (a >= TB_BASE + 32'(4 * DEPTH)))) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_pc = TB_BASE; m_instr = '0; m_ipc = '0; m_valid = 1'b0; m_fault = 1'b0;
    endtask

    task automatic model_load(input logic [31:0] a);
        m_pc    = a;
        m_valid = 1'b0;
        if (addr_bad(a)) m_fault = 1'b1;
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".mem_addr"},    mem_addr,    m_pc);
        check({ctx, ".instr_valid"}, 32'(instr_valid), 32'(m_valid));
        check({ctx, ".instr"},       instr,       m_instr);
        check({ctx, ".instr_pc"},    instr_pc,    m_ipc);
        check({ctx, ".fault"},       32'(fault),  32'(m_fault));
    endtask

    // Called at a falling edge: drive inputs, advance model, run one clock, compare.
    task automatic cycle(input bit rv, input logic [31:0] rpc, input bit rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        if (!m_fault) begin
            if (m_valid && rdy)
                $display("xact consume pc=%h instr=%h%s", m_ipc, m_instr, rv ? " redirect" : "");
            if (rv)
                model_load(rpc);
            else if (!m_valid) begin
                m_instr = mem[m_pc[6:2]];
                m_ipc   = m_pc;
                m_valid = 1'b1;
            end else if (rdy)
                model_load(m_pc + 32'd4);
        end
        @(posedge clk);
        @(negedge clk);
        check_all("cyc");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit          rv, rdy;
        int          k, fault_age;
        logic [31:0] rpc;

        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0010_0113;
        model_reset();

        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // In-order fetch with ready high: valid on cycles 1 and 3.
        cycle(1'b0, '0, 1'b1);
        check("plan_i0", instr, 32'h0050_0093);
        check("plan_pc0", instr_pc, TB_BASE);
        cycle(1'b0, '0, 1'b1);
        check("plan_gap", 32'(instr_valid), 32'd0);
        cycle(1'b0, '0, 1'b1);
        check("plan_i1", instr, 32'h0010_0113);
        check("plan_pc1", instr_pc, 32'h0040_0004);

        // Back-pressure: held for 5 cycles, then consumed.
        repeat (5) cycle(1'b0, '0, 1'b0);
        check("hold_instr", instr, 32'h0010_0113);
        check("hold_addr", mem_addr, 32'h0040_0004);
        cycle(1'b0, '0, 1'b1);
        check("adv_addr", mem_addr, 32'h0040_0008);

        // Redirect with ready in VALID.
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 32'h0040_0010, 1'b1);
        check("redir_addr", mem_addr, 32'h0040_0010);
        cycle(1'b0, '0, 1'b1);
        check("redir_pc", instr_pc, 32'h0040_0010);
        check("redir_valid", 32'(instr_valid), 32'd1);

        // Misaligned redirect is fatal until reset.
        cycle(1'b1, 32'h0040_0016, 1'b0);
        check("mis_fault", 32'(fault), 32'd1);
        check("mis_valid", 32'(instr_valid), 32'd0);
        cycle(1'b1, TB_BASE, 1'b1);
        check("mis_ignore", mem_addr, 32'h0040_0016);
        do_reset();
        check("mis_clear", 32'(fault), 32'd0);

        // Running off the end of the text segment.
        cycle(1'b1, 32'h0040_007C, 1'b1);
        cycle(1'b0, '0, 1'b1);
        check("end_pc", instr_pc, 32'h0040_007C);
        cycle(1'b0, '0, 1'b1);
        check("end_fault", 32'(fault), 32'(BCHK));
        check("end_addr", mem_addr, 32'h0040_0080);
        if (!BCHK) begin
            cycle(1'b0, '0, 1'b1);
            check("end_alias", instr, mem[0]);
        end
        do_reset();

        // Asynchronous reset in the middle of a VALID cycle.
        cycle(1'b0, '0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(instr_valid), 32'd0);
        check("async_addr", mem_addr, TB_BASE);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic.
        fault_age = 0;
        for (int c = 0; c < 1500; c++) begin
            if (m_fault) begin
                fault_age++;
                if (fault_age > 3) begin
                    do_reset();
                    fault_age = 0;
                    continue;
                end
            end
            rv  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            k   = $urandom_range(0, 39);
            rpc = TB_BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            if (k == 0)      rpc = rpc + 32'($urandom_range(1, 3));
            else if (k == 1) rpc = TB_BASE + 32'h7C;
            else if (k == 2) rpc = $urandom & 32'hFFFF_FFFC;
            else if (k == 3) rpc = 32'hFFFF_FFFC;
            cycle(rv, rpc, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
